// File: rtl/gray_pkg.sv
// Shared types, constants and helpers for the Gray-code source.
package gray_pkg;

    localparam int unsigned N     = 4;
    localparam int unsigned AN_W  = 8;
    localparam int unsigned SEG_W = 7;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } estado_t;

    // Active-low segment patterns, bit order g..a
    localparam logic [SEG_W-1:0] SEG_CERO = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_UNO  = 7'b1111001;

    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/escaneo_display.sv
// Seven-segment scanner: shows gray[d] as a 0/1 digit on digit d (d = 0..3).
// Ports: clk, reset (async, active-low), gray (value to show),
//        anodo (digit enables, active-low), catodos (segments g..a, active-low).
module escaneo_display
    import gray_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     gray,
    output logic [AN_W-1:0]  anodo,
    output logic [SEG_W-1:0] catodos
);

    localparam int unsigned SW = $clog2(SCAN_DIV);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    digito;

    // Slot timer, digit index and registered digit drive
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            digito   <= '0;
            anodo    <= 8'hFE;
            catodos  <= SEG_CERO;
        end else begin
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                digito   <= digito + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            // Upper four digits stay dark; anodo and catodos track the same digit
            anodo   <= ~(AN_W'(1) << digito);
            catodos <= gray[digito] ? SEG_UNO : SEG_CERO;
        end
    end

endmodule

// File: rtl/generador_codigogray.sv
// Gray-code source: 4-bit up/down counter advanced by a free-running tick
// (AUTO) or a synchronized step button edge (MANUAL), with Gray output,
// binary LEDs and a 4-digit 0/1 display of the Gray bits.
// Ports: clk, reset (async, active-low), run/dir switches, step button,
//        gray + gray_valid pulse, led (binary count), anodo/catodos display.
module generador_codigogray
    import gray_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             dir,
    input  logic             step,
    output logic [N-1:0]     gray,
    output logic             gray_valid,
    output logic [N-1:0]     led,
    output logic [AN_W-1:0]  anodo,
    output logic [SEG_W-1:0] catodos
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [1:0]    run_s, dir_s, step_s;
    logic          step_prev, step_pulse;
    estado_t       estado, estado_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [N-1:0]  bin, bin_nxt;
    logic          avance;

    // Two-flop synchronizers plus registered step edge pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_s      <= '0;
            dir_s      <= '0;
            step_s     <= '0;
            step_prev  <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            run_s      <= {run_s[0], run};
            dir_s      <= {dir_s[0], dir};
            step_s     <= {step_s[0], step};
            step_prev  <= step_s[1];
            step_pulse <= step_s[1] & ~step_prev;
        end
    end

    // Next-state, prescaler and advance decision
    always_comb begin
        estado_nxt = estado;
        presc_nxt  = presc;
        avance     = 1'b0;
        bin_nxt    = bin;
        case (estado)
            MANUAL: begin
                presc_nxt = '0;
                if (run_s[1]) begin
                    estado_nxt = AUTO;
                end else if (step_pulse) begin
                    avance = 1'b1;
                end
            end
            AUTO: begin
                if (!run_s[1]) begin
                    // Leaving AUTO discards any partial tick
                    estado_nxt = MANUAL;
                    presc_nxt  = '0;
                end else if (presc == PW'(TICK_DIV - 1)) begin
                    presc_nxt = '0;
                    avance    = 1'b1;
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            default: begin
                estado_nxt = MANUAL;
                presc_nxt  = '0;
            end
        endcase
        if (avance) begin
            bin_nxt = dir_s[1] ? bin - N'(1) : bin + N'(1);
        end
    end

    // State, prescaler, count and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado     <= MANUAL;
            presc      <= '0;
            bin        <= '0;
            gray       <= '0;
            gray_valid <= 1'b0;
        end else begin
            estado     <= estado_nxt;
            presc      <= presc_nxt;
            bin        <= bin_nxt;
            gray       <= bin2gray(bin_nxt);
            gray_valid <= avance;
        end
    end

    assign led = bin;

    escaneo_display #(
        .SCAN_DIV (SCAN_DIV)
    ) u_display (
        .clk     (clk),
        .reset   (reset),
        .gray    (gray),
        .anodo   (anodo),
        .catodos (catodos)
    );

endmodule

// File: tb/tb_generador_codigogray.sv
// Directed bench for generador_codigogray with short tick and scan periods.
module tb_generador_codigogray;

    logic       clk = 1'b0;
    logic       reset, run, dir, step;
    logic [3:0] gray, led;
    logic       gray_valid;
    logic [7:0] anodo;
    logic [6:0] catodos;

    int total  = 0;
    int passed = 0;

    // Hand-derived Gray code of 0..15
    localparam logic [3:0] GTAB [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                         4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    localparam logic [6:0] C0 = 7'b1000000;
    localparam logic [6:0] C1 = 7'b1111001;

    generador_codigogray #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .dir        (dir),
        .step       (step),
        .gray       (gray),
        .gray_valid (gray_valid),
        .led        (led),
        .anodo      (anodo),
        .catodos    (catodos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gray"},  32'(gray), 32'h0);
        chk({tag, "_led"},   32'(led), 32'h0);
        chk({tag, "_valid"}, 32'(gray_valid), 32'h0);
        chk({tag, "_anodo"}, 32'(anodo), 32'hFE);
        chk({tag, "_cat"},   32'(catodos), 32'(C0));
    endtask

    // One step pulse in MANUAL: gray must change exactly 4 edges later
    task automatic do_step(input logic [3:0] e_led, input logic [3:0] e_gray,
                           input logic [3:0] p_gray);
        step = 1'b1;
        wait_cyc(3);
        chk("step_hold_gray", 32'(gray), 32'(p_gray));
        chk("step_hold_valid", 32'(gray_valid), 32'h0);
        wait_cyc(1);
        chk("step_gray", 32'(gray), 32'(e_gray));
        chk("step_led", 32'(led), 32'(e_led));
        chk("step_valid", 32'(gray_valid), 32'h1);
        chk("step_onebit", 32'($countones(gray ^ p_gray)), 32'h1);
        step = 1'b0;
        wait_cyc(1);
        chk("step_valid_off", 32'(gray_valid), 32'h0);
        wait_cyc(3);
    endtask

    task automatic wait_anodo(input logic [7:0] v);
        int n = 0;
        while (anodo !== v && n < 20) begin
            wait_cyc(1);
            n++;
        end
        chk("wait_anodo", 32'(anodo), 32'(v));
    endtask

    initial begin
        logic [7:0] e_an [4];
        logic [6:0] e_cat [4];
        int k;

        // Reset state
        reset = 1'b0; run = 1'b0; dir = 1'b0; step = 1'b0;
        wait_cyc(2);
        chk_reset_vals("rst");
        reset = 1'b1;
        wait_cyc(3);

        // MANUAL, count up: 0001, 0011, 0010, 0110, 0111, 0101
        do_step(4'd1, 4'b0001, 4'b0000);
        do_step(4'd2, 4'b0011, 4'b0001);
        do_step(4'd3, 4'b0010, 4'b0011);
        do_step(4'd4, 4'b0110, 4'b0010);
        do_step(4'd5, 4'b0111, 4'b0110);
        do_step(4'd6, 4'b0101, 4'b0111);

        // No step in MANUAL: count holds
        wait_cyc(20);
        chk("manual_hold", 32'(led), 32'd6);

        // Display with gray = 0101
        e_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
        e_cat = '{C1, C0, C1, C0};
        wait_anodo(8'hF7);
        wait_anodo(8'hFE);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 2; c++) begin
                chk("scan_anodo", 32'(anodo), 32'(e_an[s]));
                chk("scan_cat", 32'(catodos), 32'(e_cat[s]));
                wait_cyc(1);
            end
        end

        // Count down from reset: 0 wraps to 15, then back up to 0
        reset = 1'b0; dir = 1'b1;
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(3);
        do_step(4'd15, 4'b1000, 4'b0000);
        dir = 1'b0;
        wait_cyc(3);
        do_step(4'd0, 4'b0000, 4'b1000);

        // AUTO with TICK_DIV = 4: first advance 7 edges after reset release
        reset = 1'b0; run = 1'b1; dir = 1'b0;
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(6);
        chk("auto_first_hold", 32'(led), 32'd0);
        wait_cyc(1);
        chk("auto_first_led", 32'(led), 32'd1);
        chk("auto_first_valid", 32'(gray_valid), 32'h1);
        for (k = 2; k <= 25; k++) begin
            if (k == 4) step = 1'b1;
            if (k == 6) step = 1'b0;
            wait_cyc(3);
            chk("auto_hold_led", 32'(led), 32'((k - 1) % 16));
            chk("auto_hold_valid", 32'(gray_valid), 32'h0);
            wait_cyc(1);
            chk("auto_led", 32'(led), 32'(k % 16));
            chk("auto_gray", 32'(gray), 32'(GTAB[k % 16]));
            chk("auto_valid", 32'(gray_valid), 32'h1);
            chk("auto_onebit", 32'($countones(gray ^ GTAB[(k - 1) % 16])), 32'h1);
        end

        // Asynchronous reset at count 9 clears outputs immediately
        #1 reset = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(6);
        chk("rerun_hold", 32'(led), 32'd0);
        wait_cyc(1);
        chk("rerun_led", 32'(led), 32'd1);
        chk("rerun_gray", 32'(gray), 32'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
